// File: rtl/we_top_pkg.sv
// Shared types and constants for the 3x3 window extractor.
// The packet-mode enum is shared so checkers can decode the top's mode register.
package we_top_pkg;

    localparam int DW = 8;

    // Low nibble of a VIP header word that marks a video packet
    localparam logic [3:0] VIP_TYPE_VIDEO = 4'h0;

    typedef logic [DW-1:0] pixel_t;
    typedef pixel_t [8:0]  window_t;

    typedef enum logic [1:0] {
        MODE_IDLE  = 2'd0,
        MODE_CTRL  = 2'd1,
        MODE_VIDEO = 2'd2
    } mode_e;

    function automatic logic is_video_header(input logic [3:0] type_code);
        return type_code == VIP_TYPE_VIDEO;
    endfunction

endpackage

// File: rtl/we_line_buffer.sv
// Single-port line store holding two delayed rows per column in one word.
// Combinational read with a clocked write gives read-before-write at the same address.
module we_line_buffer #(
    parameter int DEPTH = 1920,
    parameter int WIDTH = 16,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             i_en,
    input  logic [AW-1:0]    i_addr,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    assign o_rdata = r_mem[i_addr];

    always_ff @(posedge clk) begin
        if (i_en) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

endmodule

// File: rtl/we_top.sv
// Causal 3x3 window extractor for 8-bit VIP video; control packets pass through.
// Handshake: sink_ready mirrors source_ready; a beat moves when sink_valid & sink_ready, output 1 clk later.
module we_top
    import we_top_pkg::*;
#(
    parameter int W  = 1920,
    parameter int H  = 1080,
    parameter int DW = we_top_pkg::DW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [DW-1:0]   sink_data,
    input  logic            sink_valid,
    input  logic            sink_sop,
    input  logic            sink_eop,
    output logic            sink_ready,
    output logic [9*DW-1:0] source_data,
    output logic            source_valid,
    output logic            source_sop,
    output logic            source_eop,
    input  logic            source_ready
);

    localparam int XW = (W > 1) ? $clog2(W) : 1;
    localparam int YW = ($clog2(H + 1) < 2) ? 2 : $clog2(H + 1);

    mode_e           r_mode;
    mode_e           w_mode_nxt;
    logic [XW-1:0]   r_x;
    logic [YW-1:0]   r_y;
    logic [DW-1:0]   r_c0 [3];
    logic [DW-1:0]   r_c1 [3];
    logic [9*DW-1:0] r_data;
    logic            r_valid;
    logic            r_sop;
    logic            r_eop;

    logic            w_adv;
    logic            w_pixel;
    logic            w_in_frame;
    logic            w_lb_en;
    logic [2*DW-1:0] w_lb_rd;
    logic [2*DW-1:0] w_lb_wr;
    logic [DW-1:0]   w_cur [3];
    logic [9*DW-1:0] w_win;
    logic [9*DW-1:0] w_out_data;

    assign sink_ready   = source_ready;
    assign w_adv        = sink_valid & source_ready;
    assign w_pixel      = w_adv & ~sink_sop & (r_mode == MODE_VIDEO);
    assign w_in_frame   = r_y < YW'(H);
    assign w_lb_en      = w_pixel & w_in_frame;
    assign w_lb_wr      = {w_cur[1], sink_data};

    assign source_data  = r_data;
    assign source_valid = r_valid;
    assign source_sop   = r_sop;
    assign source_eop   = r_eop;

    // Upper half: row y-2, lower half: row y-1 at column x
    we_line_buffer #(
        .DEPTH (W),
        .WIDTH (2 * DW),
        .AW    (XW)
    ) u_line_buffer (
        .clk     (clk),
        .i_en    (w_lb_en),
        .i_addr  (r_x),
        .i_wdata (w_lb_wr),
        .o_rdata (w_lb_rd)
    );

    // Current column with rows above the frame masked; stored columns inherit the mask
    always_comb begin
        w_cur[0] = (r_y >= YW'(2)) ? w_lb_rd[2*DW-1:DW] : '0;
        w_cur[1] = (r_y >= YW'(1)) ? w_lb_rd[DW-1:0]    : '0;
        w_cur[2] = sink_data;
        w_win    = '0;
        if (w_in_frame) begin
            for (int r = 0; r < 3; r++) begin
                w_win[DW*(3*r)     +: DW] = (r_x == '0) ? '0 : r_c0[r];
                w_win[DW*(3*r + 1) +: DW] = (r_x == '0) ? '0 : r_c1[r];
                w_win[DW*(3*r + 2) +: DW] = w_cur[r];
            end
        end
    end

    assign w_out_data = w_pixel ? w_win : {{(8*DW){1'b0}}, sink_data};

    always_comb begin
        w_mode_nxt = r_mode;
        if (w_adv) begin
            if (sink_sop) begin
                if (sink_eop) begin
                    w_mode_nxt = MODE_IDLE;
                end else if (is_video_header(sink_data[3:0])) begin
                    w_mode_nxt = MODE_VIDEO;
                end else begin
                    w_mode_nxt = MODE_CTRL;
                end
            end else if (sink_eop) begin
                w_mode_nxt = MODE_IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode <= MODE_IDLE;
        end else begin
            r_mode <= w_mode_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x     <= '0;
            r_y     <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_sop   <= 1'b0;
            r_eop   <= 1'b0;
            for (int r = 0; r < 3; r++) begin
                r_c0[r] <= '0;
                r_c1[r] <= '0;
            end
        end else begin
            if (w_adv) begin
                r_valid <= 1'b1;
                r_data  <= w_out_data;
                r_sop   <= sink_sop;
                r_eop   <= sink_eop;
            end else if (source_ready) begin
                r_valid <= 1'b0;
            end

            if (w_adv && sink_sop) begin
                r_x <= '0;
                r_y <= '0;
            end else if (w_lb_en) begin
                if (r_x == XW'(W - 1)) begin
                    r_x <= '0;
                    r_y <= r_y + YW'(1);
                end else begin
                    r_x <= r_x + XW'(1);
                end
                // Start of line clears the older column so x-2 reads as zero at x = 1
                for (int r = 0; r < 3; r++) begin
                    r_c0[r] <= (r_x == '0) ? '0 : r_c1[r];
                    r_c1[r] <= w_cur[r];
                end
            end
        end
    end

endmodule

// File: tb/tb_we_top.sv
// Directed bench for we_top with W=4, H=3: reset, windows, control pass-through,
// backpressure freeze and overlong frames, checked against hand values and a pixel model.
module tb_we_top;

    localparam int W  = 4;
    localparam int H  = 3;
    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [DW-1:0]   sink_data;
    logic            sink_valid;
    logic            sink_sop;
    logic            sink_eop;
    logic            sink_ready;
    logic [9*DW-1:0] source_data;
    logic            source_valid;
    logic            source_sop;
    logic            source_eop;
    logic            source_ready;

    int n_run  = 0;
    int n_fail = 0;

    logic [9*DW-1:0] got_win [16];

    we_top #(.W(W), .H(H), .DW(DW)) dut (
        .clk          (clk),
        .rst          (rst),
        .sink_data    (sink_data),
        .sink_valid   (sink_valid),
        .sink_sop     (sink_sop),
        .sink_eop     (sink_eop),
        .sink_ready   (sink_ready),
        .source_data  (source_data),
        .source_valid (source_valid),
        .source_sop   (source_sop),
        .source_eop   (source_eop),
        .source_ready (source_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_run++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Rows listed top to bottom, columns left to right
    function automatic logic [71:0] mkwin(input logic [7:0] a0, a1, a2, b0, b1, b2, c0, c1, c2);
        return {c2, c1, c0, b2, b1, b0, a2, a1, a0};
    endfunction

    // Frame pixel i carries value i+1; beyond W*H pixels the window is all zero
    function automatic logic [71:0] model_win(input int i);
        logic [71:0] w;
        int x, y, px, py;
        w = '0;
        if (i >= W * H) return w;
        x = i % W;
        y = i / W;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                px = x - 2 + c;
                py = y - 2 + r;
                if (px >= 0 && py >= 0) w[8*(3*r + c) +: 8] = 8'(py * W + px + 1);
            end
        end
        return w;
    endfunction

    task automatic beat(input logic [7:0] d, input logic sop, input logic eop);
        @(negedge clk);
        source_ready = 1'b1;
        sink_data    = d;
        sink_valid   = 1'b1;
        sink_sop     = sop;
        sink_eop     = eop;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        sink_valid = 1'b0;
        sink_sop   = 1'b0;
        sink_eop   = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic frame(input string name, input int npix, input int stall_before);
        beat(8'h00, 1'b1, 1'b0);
        check({name, " hdr data"}, source_data, 72'h0);
        check({name, " hdr sop"}, source_sop, 1'b1);
        check({name, " hdr valid"}, source_valid, 1'b1);
        for (int i = 0; i < npix; i++) begin
            if (i == stall_before) begin
                @(negedge clk);
                source_ready = 1'b0;
                sink_valid   = 1'b1;
                sink_data    = 8'(i + 1);
                sink_sop     = 1'b0;
                sink_eop     = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    @(posedge clk);
                    #1;
                    check($sformatf("%s stall%0d sink_ready", name, s), sink_ready, 1'b0);
                    check($sformatf("%s stall%0d data", name, s), source_data, model_win(i - 1));
                    check($sformatf("%s stall%0d valid", name, s), source_valid, 1'b1);
                end
            end
            beat(8'(i + 1), 1'b0, i == npix - 1);
            got_win[i] = source_data;
            check($sformatf("%s px%0d win", name, i), source_data, model_win(i));
            check($sformatf("%s px%0d eop", name, i), source_eop, i == npix - 1);
            check($sformatf("%s px%0d sop", name, i), source_sop, 1'b0);
        end
    endtask

    initial begin
        rst          = 1'b1;
        sink_data    = '0;
        sink_valid   = 1'b0;
        sink_sop     = 1'b0;
        sink_eop     = 1'b0;
        source_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst valid", source_valid, 1'b0);
        check("rst data", source_data, 72'h0);
        check("rst sop", source_sop, 1'b0);
        check("rst eop", source_eop, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Reset mid-stream clears outputs without waiting for a clock
        beat(8'h00, 1'b1, 1'b0);
        beat(8'h09, 1'b0, 1'b0);
        check("pre-rst valid", source_valid, 1'b1);
        #3;
        rst = 1'b1;
        #1;
        check("async rst valid", source_valid, 1'b0);
        check("async rst data", source_data, 72'h0);
        check("async rst sop", source_sop, 1'b0);
        @(posedge clk);
        #1;
        check("held rst valid", source_valid, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Non-sop beat while idle is forwarded as a control word
        beat(8'h33, 1'b0, 1'b0);
        check("idle fwd data", source_data, 72'h33);
        check("idle fwd valid", source_valid, 1'b1);
        idle_cycle();
        check("bubble valid", source_valid, 1'b0);

        // Frame A: hand-computed windows
        frame("A", 12, -1);
        check("A corner", got_win[0], mkwin(0, 0, 0, 0, 0, 0, 0, 0, 1));
        check("A (1,1)", got_win[5], mkwin(0, 0, 0, 0, 1, 2, 0, 5, 6));
        check("A (2,2)", got_win[10], mkwin(1, 2, 3, 5, 6, 7, 9, 10, 11));
        check("A last px", {64'h0, got_win[11][71:64]}, 72'd12);
        idle_cycle();

        // Control packet passes through untouched
        beat(8'h0F, 1'b1, 1'b0);
        check("ctl hdr data", source_data, 72'h0F);
        check("ctl hdr sop", source_sop, 1'b1);
        beat(8'hAA, 1'b0, 1'b0);
        check("ctl AA data", source_data, 72'hAA);
        check("ctl AA eop", source_eop, 1'b0);
        beat(8'h55, 1'b0, 1'b1);
        check("ctl 55 data", source_data, 72'h55);
        check("ctl 55 eop", source_eop, 1'b1);

        // Frame B starts fresh after the control packet
        frame("B", 12, -1);
        check("B corner", got_win[0], mkwin(0, 0, 0, 0, 0, 0, 0, 0, 1));

        // Frame C stalls for 3 cycles before pixel (2,1)
        frame("C", 12, 6);
        check("C (2,2)", got_win[10], mkwin(1, 2, 3, 5, 6, 7, 9, 10, 11));

        // Frame D overruns by two pixels, frame E must be unaffected
        frame("D", 14, -1);
        check("D px13 zero", got_win[12], 72'h0);
        check("D px14 zero", got_win[13], 72'h0);
        frame("E", 12, -1);
        check("E (1,1)", got_win[5], mkwin(0, 0, 0, 0, 1, 2, 0, 5, 6));
        idle_cycle();

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/we_top.md
Name: we_top

Overview:
- Streaming 3x3 window extractor for 8-bit greyscale video over Avalon-ST video, using Altera VIP packet format.
- For each active pixel it emits the causal 3x3 neighbourhood ending at that pixel, as one 72-bit beat.
- Sits between a video source and filter or morphology stages.
- Non-video (control) packets pass through untouched.

Parameters:
- W, 1920, active pixels per line (line-buffer depth).
- H, 1080, active lines per frame.
- DW, 8, pixel width in bits.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- sink_data  in  DW  input pixel or header word.
- sink_valid  in  1  input beat valid.
- sink_sop  in  1  first beat of a packet (header word).
- sink_eop  in  1  last beat of a packet.
- sink_ready  out  1  input may be accepted.
- source_data  out  9*DW  output window or passthrough word.
- source_valid  out  1  output beat valid.
- source_sop  out  1  output start of packet.
- source_eop  out  1  output end of packet.
- source_ready  in  1  downstream accepts this cycle.

Behaviour:
- Reset is asynchronous, active-high, with clock clk.
  - On rst: source_valid, source_sop, source_eop and source_data = 0.
  - Pixel counters x and y = 0; packet mode = idle.
  - Line-buffer contents are don't-care and are masked by the border rule.
- Handshake:
  - sink_ready = source_ready (combinational); the whole pipeline stalls when source_ready = 0.
  - Beat accepted when sink_valid & sink_ready.
- Latency: exactly 1 clk from accept to the corresponding output beat. Output registers hold their values while stalled.
- When no beat is accepted in a cycle in which source_ready = 1, source_valid goes to 0 on the next edge.
- Packet type:
  - Sop beat with sink_data[3:0] = 0 is a video packet; any other value is a control packet.
  - The sop beat itself is forwarded with source_data = zero-extended sink_data and source_sop = 1.
- Control packet: every beat forwarded with source_data = zero-extended sink_data; sop and eop copied; counters untouched.
- Video packet:
  - Each non-sop beat is a pixel at (x, y), raster order.
  - x wraps W-1 -> 0 and increments y.
  - After pixel (W-1, H-1), further pixels are out-of-frame and output an all-zero window.
- Window contents:
  - w[r][c] = pixel(x-2+c, y-2+r), for r, c in 0..2.
  - Any negative coordinate gives 0; there is no look-ahead.
  - Packing: source_data[DW*(3r+c) +: DW] = w[r][c]. w[2][2] is the current pixel in bits [71:64]; w[1][1] is the centre.
- Storage:
  - Two line buffers of depth W hold rows y-1 and y-2.
  - A 3x3 shift register holds the columns.
  - Columns are cleared at x = 0; rows are masked when y < 1 or y < 2.
- eop:
  - source_eop is copied from sink_eop.
  - An early eop (fewer than W*H pixels) is forwarded normally.
  - The next sop resets x and y to 0 regardless of the count reached.
- sop inside a packet (no eop): treated as a new packet; counters reset.
- Mid-packet reset: all state clears; the first beat after reset must be a sop. Non-sop beats in idle mode are forwarded as control beats.

Decomposition:
- Shared package: DW, pixel type (logic [DW-1:0]), window type (9 x pixel), VIP type code constant VIP_TYPE_VIDEO = 4'h0.
- One sub-module, we_line_buffer: single-port RAM of depth W and width 2*DW, read-before-write at address x, enabled by pipeline advance. It stores both delayed rows in one word.

Test Plan (W=4, H=3, source_ready = 1 unless stated; video packet = header 0x00 followed by pixels with values 1..12):
- Reset: assert rst mid-stream -> all outputs 0 immediately. After release, header 0x00 -> source_sop = 1 and source_data = 0 one cycle later.
- Corner pixel (0,0), value 1 -> window all 0 except w[2][2] = 1.
- Pixel (1,1), value 6 -> row 0 = {0,0,0}, row 1 = {0,1,2}, row 2 = {0,5,6}.
- Pixel (2,2), value 11 -> rows {1,2,3}, {5,6,7}, {9,10,11}. The eop on pixel 12 gives source_eop = 1 with w[2][2] = 12.
- Control packet: header 0x0F, then 0xAA, 0x55 with eop -> same three words forwarded zero-extended. A following video frame starts at (0,0) with the window result of the corner scenario.
- Backpressure: source_ready = 0 for 3 cycles mid-line -> sink_ready = 0 and outputs frozen. After release the window sequence equals the unstalled run.
- Overlong packet of 14 pixels -> pixels 13 and 14 give all-zero windows. Next frame is correct.
